// File: rtl/rc4_crack_monitor.sv
// ============================================================================
//  Module   : rc4_crack_monitor
//  Purpose  : Sequences an RC4 key-search engine and shows its progress and
//             result on six seven-segment digits and three status LEDs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rc4_crack_monitor #(
  parameter int REFRESH_CYCLES = 5000000,
  parameter int BLINK_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        rc4_ready,
  input  logic        rc4_finish,
  input  logic        rc4_failure,
  input  logic [23:0] current_key,
  output logic        rc4_start,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [23:0] found_key,
  output logic        led_busy,
  output logic        led_found,
  output logic        led_fail
);

  localparam int c_ref_w   = $clog2(REFRESH_CYCLES);
  localparam int c_blink_w = $clog2(BLINK_CYCLES);
  localparam logic [c_ref_w-1:0]   c_ref_max   = c_ref_w'(REFRESH_CYCLES - 1);
  localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_CYCLES - 1);
  localparam logic [6:0] c_blank = 7'b1111111;
  localparam logic [6:0] c_dash  = 7'b0111111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_FOUND = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ref_w-1:0]   r_ref_cnt;
  logic [c_ref_w-1:0]   w_ref_nxt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic [c_blink_w-1:0] w_blink_nxt;
  logic [23:0]          r_disp_key;
  logic [23:0]          w_disp_nxt;
  logic [23:0]          w_found_nxt;
  logic [23:0]          w_shown;
  logic                 w_fail_nxt;
  logic [6:0]           w_hex [6];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (go) w_state_nxt = S_ARM;
      S_ARM:   if (rc4_ready) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN:   if (rc4_finish) w_state_nxt = rc4_failure ? S_FAIL : S_FOUND;
      S_FOUND, S_FAIL: if (go) w_state_nxt = S_ARM;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they track the state
  // register with no extra cycle of lag.
  always_comb begin
    w_ref_nxt   = r_ref_cnt;
    w_blink_nxt = r_blink_cnt;
    w_disp_nxt  = r_disp_key;
    w_found_nxt = found_key;
    w_fail_nxt  = 1'b0;
    case (r_state)
      S_START: w_ref_nxt = '0;
      S_RUN: begin
        if (rc4_finish) begin
          if (!rc4_failure) begin
            w_found_nxt = current_key;
            w_disp_nxt  = current_key;
          end
        end else if (r_ref_cnt == c_ref_max) begin
          w_ref_nxt  = '0;
          w_disp_nxt = current_key;
        end else begin
          w_ref_nxt = r_ref_cnt + 1'b1;
        end
      end
      S_FOUND, S_FAIL: begin
        if (go) begin
          w_ref_nxt   = '0;
          w_blink_nxt = '0;
          w_disp_nxt  = '0;
        end
      end
      default: ;
    endcase

    if (w_state_nxt == S_FAIL) begin
      if (r_state != S_FAIL) begin
        w_blink_nxt = '0;
        w_fail_nxt  = 1'b1;
      end else if (r_blink_cnt == c_blink_max) begin
        w_blink_nxt = '0;
        w_fail_nxt  = ~led_fail;
      end else begin
        w_blink_nxt = r_blink_cnt + 1'b1;
        w_fail_nxt  = led_fail;
      end
    end

    w_shown = (w_state_nxt == S_FOUND) ? w_found_nxt : w_disp_nxt;
    for (int i = 0; i < 6; i++) begin
      case (w_state_nxt)
        S_IDLE:  w_hex[i] = c_blank;
        S_FAIL:  w_hex[i] = c_dash;
        default: w_hex[i] = seg7(w_shown[i*4 +: 4]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_cnt   <= '0;
      r_blink_cnt <= '0;
      r_disp_key  <= '0;
      found_key   <= '0;
      rc4_start   <= 1'b0;
      led_busy    <= 1'b0;
      led_found   <= 1'b0;
      led_fail    <= 1'b0;
      hex5        <= c_blank;
      hex4        <= c_blank;
      hex3        <= c_blank;
      hex2        <= c_blank;
      hex1        <= c_blank;
      hex0        <= c_blank;
    end else begin
      r_ref_cnt   <= w_ref_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_disp_key  <= w_disp_nxt;
      found_key   <= w_found_nxt;
      rc4_start   <= (w_state_nxt == S_START);
      led_busy    <= (w_state_nxt == S_ARM) || (w_state_nxt == S_START) ||
                     (w_state_nxt == S_RUN);
      led_found   <= (w_state_nxt == S_FOUND);
      led_fail    <= w_fail_nxt;
      hex5        <= w_hex[5];
      hex4        <= w_hex[4];
      hex3        <= w_hex[3];
      hex2        <= w_hex[2];
      hex1        <= w_hex[1];
      hex0        <= w_hex[0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rc4_crack_monitor.sv
// ============================================================================
//  Module   : tb_rc4_crack_monitor
//  Purpose  : Scoreboard bench for rc4_crack_monitor with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rc4_crack_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, rc4_ready, rc4_finish, rc4_failure;
  logic [23:0] current_key;
  logic        rc4_start;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic [23:0] found_key;
  logic        led_busy, led_found, led_fail;

  rc4_crack_monitor #(.REFRESH_CYCLES(4), .BLINK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .go(go), .rc4_ready(rc4_ready),
    .rc4_finish(rc4_finish), .rc4_failure(rc4_failure),
    .current_key(current_key), .rc4_start(rc4_start),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .found_key(found_key), .led_busy(led_busy), .led_found(led_found),
    .led_fail(led_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  flags;   // {rc4_start, led_busy, led_found, led_fail}
    logic [23:0] key;
    logic [41:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [41:0] BLANK = {6{7'b1111111}};
  localparam logic [41:0] DASH  = {6{7'b0111111}};

  function automatic logic [41:0] digits(input logic [23:0] k);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg_tab[k[i*4 +: 4]];
    return r;
  endfunction

  task automatic expect_out(input string n, input logic s, input logic b,
                            input logic f, input logic l,
                            input logic [23:0] fk, input logic [41:0] hx);
    exp_t e;
    e.name = n; e.flags = {s, b, f, l}; e.key = fk; e.hex = hx;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the current outputs against each queued expectation
  // on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [3:0]  af;
      logic [41:0] ah;
      e  = exp_q.pop_front();
      af = {rc4_start, led_busy, led_found, led_fail};
      ah = {hex5, hex4, hex3, hex2, hex1, hex0};
      total_cnt++;
      if (af === e.flags && ah === e.hex && found_key === e.key)
        pass_cnt++;
      else
        $display("FAIL %s: got flags=%b key=%h hex=%h, expected flags=%b key=%h hex=%h",
                 e.name, af, found_key, ah, e.flags, e.key, e.hex);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; go = 1'b0; rc4_ready = 1'b0; rc4_finish = 1'b0;
    rc4_failure = 1'b0; current_key = 24'h0;
    tick();
    expect_out("reset", 0, 0, 0, 0, 24'h0, BLANK);
    tick();

    // IDLE ignores everything except go
    reset = 1'b1; rc4_ready = 1'b1; rc4_finish = 1'b1;
    tick();
    expect_out("idle_ignore", 0, 0, 0, 0, 24'h0, BLANK);

    go = 1'b1; rc4_ready = 1'b0; rc4_finish = 1'b0;
    tick();
    expect_out("arm", 0, 1, 0, 0, 24'h0, digits(24'h0));

    go = 1'b0; rc4_finish = 1'b1;
    tick();
    expect_out("arm_hold", 0, 1, 0, 0, 24'h0, digits(24'h0));

    rc4_finish = 1'b0; rc4_ready = 1'b1;
    tick();
    expect_out("start", 1, 1, 0, 0, 24'h0, digits(24'h0));

    rc4_ready = 1'b0; current_key = 24'h00ABCD; go = 1'b1;
    tick();
    expect_out("run_entry", 0, 1, 0, 0, 24'h0, digits(24'h0));
    tick();
    tick();
    tick();
    expect_out("run_pre_snap", 0, 1, 0, 0, 24'h0, digits(24'h0));
    tick();
    expect_out("snapshot", 0, 1, 0, 0, 24'h0, digits(24'h00ABCD));

    go = 1'b0; current_key = 24'h1234EF; rc4_finish = 1'b1; rc4_failure = 1'b0;
    tick();
    expect_out("found", 0, 0, 1, 0, 24'h1234EF, digits(24'h1234EF));

    rc4_finish = 1'b0; current_key = 24'h777777;
    tick();
    expect_out("found_hold", 0, 0, 1, 0, 24'h1234EF, digits(24'h1234EF));

    // go to rc4_start latency of two cycles
    go = 1'b1; rc4_ready = 1'b1;
    tick();
    expect_out("rearm", 0, 1, 0, 0, 24'h1234EF, digits(24'h0));
    go = 1'b0;
    tick();
    expect_out("start2", 1, 1, 0, 0, 24'h1234EF, digits(24'h0));
    rc4_ready = 1'b0;
    tick();
    expect_out("run2", 0, 1, 0, 0, 24'h1234EF, digits(24'h0));

    current_key = 24'h555555; rc4_finish = 1'b1; rc4_failure = 1'b1;
    tick();
    expect_out("fail_0", 0, 0, 0, 1, 24'h1234EF, DASH);
    rc4_finish = 1'b0; rc4_failure = 1'b0;
    tick(); expect_out("fail_1", 0, 0, 0, 1, 24'h1234EF, DASH);
    tick(); expect_out("fail_2", 0, 0, 0, 1, 24'h1234EF, DASH);
    tick(); expect_out("fail_3", 0, 0, 0, 0, 24'h1234EF, DASH);
    tick(); expect_out("fail_4", 0, 0, 0, 0, 24'h1234EF, DASH);
    tick(); expect_out("fail_5", 0, 0, 0, 0, 24'h1234EF, DASH);
    tick(); expect_out("fail_6", 0, 0, 0, 1, 24'h1234EF, DASH);

    go = 1'b1;
    tick();
    expect_out("fail_rearm", 0, 1, 0, 0, 24'h1234EF, digits(24'h0));
    go = 1'b0; rc4_ready = 1'b1;
    tick();
    rc4_ready = 1'b0;
    tick();
    tick();

    // asynchronous reset between edges while running
    @(posedge clk);
    #2;
    reset = 1'b0;
    expect_out("async_reset", 0, 0, 0, 0, 24'h0, BLANK);
    tick();
    reset = 1'b1; rc4_ready = 1'b1;
    tick();
    expect_out("post_reset_idle", 0, 0, 0, 0, 24'h0, BLANK);
    go = 1'b1;
    tick();
    expect_out("restart_arm", 0, 1, 0, 0, 24'h0, digits(24'h0));
    go = 1'b0;
    tick();
    expect_out("restart_start", 1, 1, 0, 0, 24'h0, digits(24'h0));
    tick();
    expect_out("restart_run", 0, 1, 0, 0, 24'h0, digits(24'h0));
    tick();
    tick();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rc4_crack_monitor.md
RC4_CRACK_MONITOR -- requirements
Module: rc4_crack_monitor

Interface
REQ-001 Parameter REFRESH_CYCLES, default 5000000: RUN-state cycles between progress-display snapshots of current_key; legal range >= 2.
REQ-002 Parameter BLINK_CYCLES, default 25000000: cycles per led_fail toggle period in FAIL; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 go  input  1  one-cycle start/restart request, synchronous to clk.
REQ-006 rc4_ready  input  1  upstream cracker idle and able to accept rc4_start.
REQ-007 rc4_finish  input  1  cracker search complete.
REQ-008 rc4_failure  input  1  qualifies rc4_finish: 1 = keyspace exhausted, 0 = key found.
REQ-009 current_key  input  24  cracker's key under test, or the found key when rc4_finish=1.
REQ-010 rc4_start  output  1  one-cycle launch pulse to the cracker.
REQ-011 hex5..hex0  output  7 each  active-low seven-segment digits, bit order {g,f,e,d,c,b,a}; hex5 = most significant nibble.
REQ-012 found_key  output  24  latched successful key.
REQ-013 led_busy, led_found, led_fail  output  1 each  status LEDs, active-high.

Function
REQ-014 FSM states SHALL be IDLE, ARM, START, RUN, FOUND, FAIL.
REQ-015 IDLE: go=1 -> ARM; all other inputs ignored.
REQ-016 ARM: rc4_ready=1 -> START; remain in ARM indefinitely otherwise.
REQ-017 START: rc4_start=1 for exactly this one cycle -> RUN; rc4_start=0 in every other state.
REQ-018 RUN: rc4_finish=1 & rc4_failure=0 -> FOUND, with found_key <= current_key on that same edge.
REQ-019 RUN: rc4_finish=1 & rc4_failure=1 -> FAIL; found_key unchanged.
REQ-020 rc4_failure SHALL be sampled only when rc4_finish=1; rc4_finish SHALL be ignored in IDLE, ARM and START.
REQ-021 FOUND/FAIL: hold state until go=1, then -> ARM, clearing the refresh counter, blink counter and display register.
REQ-022 go SHALL be ignored in ARM, START and RUN.
REQ-023 Refresh counter: counts only in RUN, from 0 to REFRESH_CYCLES-1, then wraps to 0; on the wrap cycle display_key <= current_key.
REQ-024 Refresh counter SHALL clear to 0 on entry to RUN; the first snapshot occurs REFRESH_CYCLES cycles after entry.
REQ-025 The finish event takes priority over a coincident refresh wrap: display_key <= current_key (FOUND) or is left unchanged (FAIL).
REQ-026 Digit encoding (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-027 IDLE: all hex digits blank (1111111). ARM/START/RUN: digits show display_key. FOUND: digits show found_key. FAIL: every digit shows a dash (0111111).
REQ-028 led_busy=1 in ARM, START, RUN; led_found=1 in FOUND only.
REQ-029 led_fail: 0 outside FAIL; in FAIL it starts at 1 and toggles every BLINK_CYCLES cycles via a wrapping counter.
REQ-030 All outputs SHALL be registered; the state-to-LED and state-to-digit latency SHALL be at most 1 cycle.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, rc4_start=0, found_key=0, display_key=0, all counters=0, hex5..hex0=1111111, all LEDs=0.
REQ-032 Reset asserted mid-RUN SHALL abort monitoring; the cracker is not signalled.
REQ-033 After reset release, the block SHALL take no action until go=1.

Verification (REFRESH_CYCLES=4, BLINK_CYCLES=3)
REQ-034 Reset, go pulse, rc4_ready=1 -> rc4_start high for exactly 1 cycle, 2 cycles after go; led_busy=1.
REQ-035 RUN with current_key=24'h00ABCD, held for 4 cycles -> hex5..hex0 show 0,0,A,b,C,d.
REQ-036 rc4_finish=1, rc4_failure=0, current_key=24'h1234EF -> found_key=24'h1234EF, led_found=1, digits show 1,2,3,4,E,F.
REQ-037 rc4_finish=1, rc4_failure=1 -> all digits 0111111; led_fail sequence 1,1,1,0,0,0,1 across successive cycles.
REQ-038 go held high during RUN -> no state change; rc4_finish pulsed in ARM with rc4_ready=0 -> state stays ARM.
REQ-039 reset=0 asserted mid-RUN between clock edges -> all outputs reach reset values before the next edge; go after release restarts normally.
